fir_stream: RTL and testbench
=============================

Name: fir_stream

Overview:
- Parametrised streaming FIR filter; successor to the fixed 5-tap, 8-bit datapath `fir` block.
- Generalises tap count and data, coefficient and output widths.
- Adds:
  - an input-valid/output-valid stream;
  - run-time coefficient loading;
  - synchronous flush;
  - a fixed 2-cycle pipelined MAC.
- Sits between the sample source and the result sink in the filter datapath. All arithmetic is unsigned.

Parameters:
- TAPS, 5, number of filter taps (2..32)
- DATA_W, 8, input sample width
- COEF_W, 8, coefficient width
- OUT_W, 10, output width
- SHIFT, 0, right shift applied to the accumulator before output sizing
- ACC_W (localparam), DATA_W+COEF_W+clog2(TAPS), full-precision accumulator width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush of delay line and pipeline
- in_valid  in  1  in_data is accepted this cycle
- in_data  in  DATA_W  input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index; 0 applies to the newest sample
- coef_data  in  COEF_W  coefficient value
- out_valid  out  1  out_data valid this cycle (single-cycle pulse per accepted sample)
- out_data  out  OUT_W  filtered sample
- out_sat  out  1  out_data was clipped (see Optional Feature)

Behaviour:
- Reset (rst high, async):
  - delay line, product registers, valid pipe, out_data, out_valid and out_sat all go to 0 immediately;
  - all coefficients go to 1, so the default filter is a TAPS-point moving sum;
  - in-flight samples are lost.
- Delay line:
  - on an edge with in_valid=1 (and clr=0), tap[0] <= in_data and tap[k] <= tap[k-1];
  - with in_valid=0 it holds; there is no shift and no output.
- Warm-up: taps start at 0, so outputs are valid from the first accepted sample with zero fill and no priming gap.
- Pipeline and latency:
  - edge E0: sample accepted;
  - edge E0+1: prod[k] <= coef[k]*tap[k], and valid stage 1 set;
  - edge E0+2: acc = sum of prod (ACC_W bits, no overflow possible); out_data is registered and out_valid=1 for exactly one cycle.
- Throughput and ordering:
  - one sample per cycle is sustained;
  - gaps in in_valid produce matching gaps in out_valid, in the same order;
  - there is no backpressure.
- Output sizing:
  - r = acc >> SHIFT;
  - if r fits in OUT_W, out_data = r;
  - otherwise, the Optional Feature rule applies.
- Coefficient write:
  - on an edge with coef_we=1, coef[coef_addr] <= coef_data;
  - coef_addr >= TAPS is ignored;
  - a product capture on the same edge as a write uses the old value, and the new value applies from the next edge;
  - writes are allowed mid-stream.
- clr:
  - on an edge with clr=1, taps, products and valid pipe are zeroed, and out_valid is 0 on the following cycle;
  - coefficients are retained;
  - clr together with in_valid: clr wins and the sample is dropped;
  - clr together with coef_we: the write still occurs.
- No FSM beyond the 2-stage valid shift register.

Optional Feature:
- Macro: FIR_STREAM_SAT_EN.
- Defined:
  - r > 2^OUT_W-1 gives out_data = 2^OUT_W-1 (all ones);
  - out_sat = 1, in the same cycle as out_valid.
- Undefined:
  - out_data = r[OUT_W-1:0] (wrap);
  - out_sat is tied to 0.
- Both builds share the same ports and latency.

Decomposition:
- Shared include fir_pkg (header file, included by both RTL and bench) holds:
  - the clog2 constant function;
  - the ACC_W derivation;
  - the coefficient reset value (1);
  - the pipeline latency constant FIR_LAT = 2.
- One sub-module, fir_adder_tree:
  - combinational sum of TAPS products of DATA_W+COEF_W bits;
  - ACC_W result;
  - instantiated between the product registers and the output register.

Test Plan:
- Default coefficients, in 10,20,30,40,50 on consecutive cycles -> out_valid from 2 cycles after first sample; out_data 10,30,60,100,150.
- Default coefficients, 255 x5, then read the 5th output:
  - with FIR_STREAM_SAT_EN -> out_data 1023, out_sat 1;
  - without -> 1275 mod 1024 = 251, out_sat 0.
- Coefficient load:
  - load coefficients 1,2,3,4,5 (addr 0..4) and write addr 7 (ignored);
  - then send impulse 1,0,0,0,0,0 -> outputs 1,2,3,4,5,0.
- Bubbles: in_valid pattern 1,0,1,1,0,1 with data 1,x,2,3,x,4 -> exactly 4 out_valid pulses, values 1,3,6,10, each 2 cycles after its sample.
- Flush: stream 100 x3, pulse clr with in_valid=1, then send 7 -> dropped sample produces no output; next output is 7.
- Async reset mid-stream:
  - assert rst between edges with a sample in flight -> out_valid and out_data go to 0 before the next edge;
  - after release, impulse 1 -> out_data 1, confirming coefficients are back to 1.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and sizing helpers for the fir_stream filter.
// Imported by the RTL and by the testbench so both agree on widths.
package fir_pkg;

   // Clocks from an accepted sample to its out_valid pulse.
   localparam int FIR_LAT = 2;

   // Coefficient value after reset: an all-ones set gives a moving sum.
   localparam int COEF_RST_VAL = 1;

   // Ceiling log2 for sizing indices and accumulator growth.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

   // Full-precision accumulator width: one product plus growth for the sum.
   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + clog2(taps);
   endfunction

   // Larger of two widths.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: combinational pairwise sum of TAPS unsigned products.
// Leaves beyond TAPS are padded with zero up to the next power of two, so
// every level halves the node count and the depth is clog2(TAPS) adders.
module fir_adder_tree
   import fir_pkg::*;
#(
   parameter int TAPS   = 5,
   parameter int PROD_W = 16,
   parameter int ACC_W  = 19
) (
   input  logic [TAPS-1:0][PROD_W-1:0] prod,
   output logic [ACC_W-1:0]            sum
);

   localparam int LEVELS = clog2(TAPS);
   localparam int LEAVES = 1 << LEVELS;

   logic [ACC_W-1:0] node_s [LEVELS+1][LEAVES];

   // Reduce the products level by level; level 0 holds the zero-padded leaves.
   always_comb begin
      for (int l = 0; l <= LEVELS; l++) begin
         for (int i = 0; i < LEAVES; i++) begin
            node_s[l][i] = {ACC_W{1'b0}};
         end
      end
      for (int i = 0; i < TAPS; i++) begin
         node_s[0][i] = ACC_W'(prod[i]);
      end
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < (LEAVES >> (l + 1)); i++) begin
            node_s[l+1][i] = node_s[l][2*i] + node_s[l][2*i+1];
         end
      end
   end

   assign sum = node_s[LEVELS][0];

endmodule

// File: rtl/fir_stream.sv
// fir_stream: parametrised unsigned streaming FIR filter.
// Accepted samples shift into a delay line, products are registered one
// clock later and the summed, sized result is registered one clock after
// that, giving a fixed 2-clock latency at one sample per clock.
// Build option: define FIR_STREAM_SAT_EN to clip out_data at all-ones and
// raise out_sat; without it out_data keeps the low OUT_W bits and out_sat
// is held at 0. Ports and latency are identical in both builds.
module fir_stream
   import fir_pkg::*;
#(
   parameter int TAPS   = 5,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = 10,
   parameter int SHIFT  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   coef_we,
   input  logic [clog2(TAPS)-1:0] coef_addr,
   input  logic [COEF_W-1:0]      coef_data,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_sat
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

   logic [DATA_W-1:0]           tap_r  [TAPS];
   logic [COEF_W-1:0]           coef_r [TAPS];
   logic [TAPS-1:0][PROD_W-1:0] prod_r;
   // vld_r[0]: sample sits in the delay line; vld_r[1]: its products are registered.
   logic [FIR_LAT-1:0]          vld_r;
   logic [ACC_W-1:0]            acc_s;
   logic                        addr_ok_s;
   logic [OUT_W-1:0]            sized_s;
   logic                        sat_s;
   logic                        out_valid_r;
   logic [OUT_W-1:0]            out_data_r;
   logic                        out_sat_r;

   // Writes to indices past the last tap are dropped.
   assign addr_ok_s = (32'(coef_addr) < TAPS);

   // Delay line: shift on each accepted sample, zero on flush, hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            tap_r[k] <= {DATA_W{1'b0}};
         end
      end else if (clr) begin
         for (int k = 0; k < TAPS; k++) begin
            tap_r[k] <= {DATA_W{1'b0}};
         end
      end else if (in_valid) begin
         tap_r[0] <= in_data;
         for (int k = 1; k < TAPS; k++) begin
            tap_r[k] <= tap_r[k-1];
         end
      end
   end

   // Coefficient bank: reset to the moving-sum set, flush leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            coef_r[k] <= COEF_W'(COEF_RST_VAL);
         end
      end else if (coef_we && addr_ok_s) begin
         coef_r[coef_addr] <= coef_data;
      end
   end

   // Product stage: sees the coefficients as they stood before this edge's write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_r <= {(TAPS*PROD_W){1'b0}};
      end else if (clr) begin
         prod_r <= {(TAPS*PROD_W){1'b0}};
      end else begin
         for (int k = 0; k < TAPS; k++) begin
            prod_r[k] <= PROD_W'(tap_r[k]) * PROD_W'(coef_r[k]);
         end
      end
   end

   // Valid pipe tracking each accepted sample through the two stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= {FIR_LAT{1'b0}};
      end else if (clr) begin
         vld_r <= {FIR_LAT{1'b0}};
      end else begin
         vld_r <= {vld_r[FIR_LAT-2:0], in_valid};
      end
   end

   fir_adder_tree #(
      .TAPS   (TAPS),
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_adder_tree (
      .prod (prod_r),
      .sum  (acc_s)
   );

`ifdef FIR_STREAM_SAT_EN
   localparam int WIDE_W = max_int(ACC_W, OUT_W) + 1;

   logic [WIDE_W-1:0] shifted_s;

   // Clip to all-ones whenever the shifted sum needs more than OUT_W bits.
   always_comb begin
      shifted_s = WIDE_W'(acc_s) >> SHIFT;
      if (|shifted_s[WIDE_W-1:OUT_W]) begin
         sized_s = {OUT_W{1'b1}};
         sat_s   = 1'b1;
      end else begin
         sized_s = shifted_s[OUT_W-1:0];
         sat_s   = 1'b0;
      end
   end
`else
   // Keep the low OUT_W bits of the shifted sum; larger results wrap.
   always_comb begin
      sized_s = OUT_W'(acc_s >> SHIFT);
      sat_s   = 1'b0;
   end
`endif

   // Output register: one-clock pulse per sample whose products were valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {OUT_W{1'b0}};
         out_sat_r   <= 1'b0;
      end else if (clr) begin
         out_valid_r <= 1'b0;
         out_sat_r   <= 1'b0;
      end else if (vld_r[FIR_LAT-1]) begin
         out_valid_r <= 1'b1;
         out_data_r  <= sized_s;
         out_sat_r   <= sat_s;
      end else begin
         out_valid_r <= 1'b0;
         out_sat_r   <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream: self-checking bench for fir_stream (default parameters).
// Directed scenarios check fixed expected values; a randomized run is
// checked against a reference that computes each result as the plain
// dot product of the coefficients and the last TAPS accepted samples.
// Honours FIR_STREAM_SAT_EN the same way the design does.
module tb_fir_stream;
   import fir_pkg::*;

   localparam int TAPS   = 5;
   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int OUT_W  = 10;
   localparam int SHIFT  = 0;
   localparam int ADDR_W = clog2(TAPS);
   localparam int OUT_MAX = (1 << OUT_W) - 1;
`ifdef FIR_STREAM_SAT_EN
   localparam int SAT5_DATA = 1023;
   localparam bit SAT5_FLAG = 1'b1;
`else
   localparam int SAT5_DATA = 251;
   localparam bit SAT5_FLAG = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              coef_we;
   logic [ADDR_W-1:0] coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_sat;

   int errors = 0;
   int checks = 0;

   // Reference state: sample history, coefficient set, results in flight.
   int     hist   [TAPS];
   int     coef_m [TAPS];
   int     snap   [TAPS];
   bit     snap_pend;
   bit     sum_pend;
   longint sum_val;
   bit     exp_valid;
   int     exp_data;
   bit     exp_sat;

   always #5 clk = ~clk;

   fir_stream #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   task automatic model_reset();
      for (int k = 0; k < TAPS; k++) begin
         hist[k]   = 0;
         coef_m[k] = 1;
         snap[k]   = 0;
      end
      snap_pend = 1'b0;
      sum_pend  = 1'b0;
      sum_val   = 0;
      exp_valid = 1'b0;
   endtask

   // Reference for one clock edge given the inputs presented on it.
   task automatic model_edge(input bit iv, input int d, input bit we, input int a, input int cd, input bit c);
      longint r;
      longint dot;
      // Result whose products were formed last edge emerges now unless flushed.
      exp_valid = sum_pend && !c;
      r = sum_val >> SHIFT;
`ifdef FIR_STREAM_SAT_EN
      if (r > OUT_MAX) begin
         exp_data = OUT_MAX;
         exp_sat  = 1'b1;
      end else begin
         exp_data = int'(r);
         exp_sat  = 1'b0;
      end
`else
      exp_data = int'(r % (OUT_MAX + 1));
      exp_sat  = 1'b0;
`endif
      // The sample accepted last edge is weighted by the coefficients held before this edge's write.
      dot = 0;
      for (int k = 0; k < TAPS; k++) dot += longint'(coef_m[k]) * longint'(snap[k]);
      sum_val  = dot;
      sum_pend = snap_pend && !c;
      if (we && a < TAPS) coef_m[a] = cd;
      if (c) begin
         for (int k = 0; k < TAPS; k++) hist[k] = 0;
         snap_pend = 1'b0;
      end else if (iv) begin
         for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = d;
         snap = hist;
         snap_pend = 1'b1;
      end else begin
         snap_pend = 1'b0;
      end
   endtask

   // Present one clock's inputs, let the edge pass, update the reference, settle.
   task automatic step(input bit iv, input int d, input bit we, input int a, input int cd, input bit c);
      in_valid  = iv;
      in_data   = DATA_W'(d);
      coef_we   = we;
      coef_addr = ADDR_W'(a);
      coef_data = COEF_W'(cd);
      clr       = c;
      @(posedge clk);
      model_edge(iv, int'(in_data), we, int'(coef_addr), int'(coef_data), c);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
      checks++;
      if (out_data !== 10'd0) begin errors++; $display("FAIL reset_data got=%0d want=0", out_data); end
      checks++;
      if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%0b want=0", out_sat); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_ramp();
      int want [5] = '{10, 30, 60, 100, 150};
      for (int i = 0; i < 8; i++) begin
         if (i < 5) step(1'b1, 10 * (i + 1), 1'b0, 0, 0, 1'b0);
         else       step(1'b0, 0, 1'b0, 0, 0, 1'b0);
         checks++;
         if (i >= 2 && i <= 6) begin
            if (out_valid !== 1'b1 || out_data !== OUT_W'(want[i-2])) begin
               errors++;
               $display("FAIL ramp_out[%0d] got valid=%0b data=%0d want valid=1 data=%0d", i, out_valid, out_data, want[i-2]);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_idle[%0d] got valid=%0b want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_saturation();
      step(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         if (i < 5) step(1'b1, 255, 1'b0, 0, 0, 1'b0);
         else       step(1'b0, 0, 1'b0, 0, 0, 1'b0);
         if (i == 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'd255 || out_sat !== 1'b0) begin
               errors++;
               $display("FAIL sat_first got valid=%0b data=%0d sat=%0b want 1/255/0", out_valid, out_data, out_sat);
            end
         end
         if (i == 6) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== OUT_W'(SAT5_DATA) || out_sat !== SAT5_FLAG) begin
               errors++;
               $display("FAIL sat_fifth got valid=%0b data=%0d sat=%0b want 1/%0d/%0b", out_valid, out_data, out_sat, SAT5_DATA, SAT5_FLAG);
            end
         end
      end
   endtask

   task automatic test_bubbles();
      bit pat_v [9] = '{1, 0, 1, 1, 0, 1, 0, 0, 0};
      int pat_d [9];
      int want  [6] = '{1, 0, 3, 6, 0, 10};
      int pulses = 0;
      pat_d = '{1, $urandom_range(0, 255), 2, 3, $urandom_range(0, 255), 4, 0, 0, 0};
      step(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         step(pat_v[i], pat_d[i], 1'b0, 0, 0, 1'b0);
         if (out_valid === 1'b1) pulses++;
         checks++;
         if (i >= 2 && pat_v[i-2]) begin
            if (out_valid !== 1'b1 || out_data !== OUT_W'(want[i-2])) begin
               errors++;
               $display("FAIL bubble_out[%0d] got valid=%0b data=%0d want valid=1 data=%0d", i, out_valid, out_data, want[i-2]);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_gap[%0d] got valid=%0b want 0", i, out_valid);
         end
      end
      checks++;
      if (pulses != 4) begin errors++; $display("FAIL bubble_count got=%0d want=4", pulses); end
   endtask

   task automatic test_flush();
      bit iv_seq [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
      int d_seq  [9] = '{100, 100, 100, 55, 7, 0, 0, 0, 0};
      bit c_seq  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      step(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         step(iv_seq[i], d_seq[i], 1'b0, 0, 0, c_seq[i]);
         checks++;
         if (i == 2 || i == 6) begin
            if (out_valid !== 1'b1 || out_data !== OUT_W'((i == 2) ? 100 : 7)) begin
               errors++;
               $display("FAIL flush_out[%0d] got valid=%0b data=%0d want valid=1 data=%0d", i, out_valid, out_data, (i == 2) ? 100 : 7);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gap[%0d] got valid=%0b data=%0d want valid=0", i, out_valid, out_data);
         end
      end
   endtask

   task automatic test_coef_load();
      int want [6] = '{1, 2, 3, 4, 5, 0};
      step(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b1, k, k + 1, 1'b0);
      step(1'b0, 0, 1'b1, 7, 99, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(i < 6, (i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0);
         checks++;
         if (i >= 2) begin
            if (out_valid !== 1'b1 || out_data !== OUT_W'(want[i-2])) begin
               errors++;
               $display("FAIL coef_impulse[%0d] got valid=%0b data=%0d want valid=1 data=%0d", i, out_valid, out_data, want[i-2]);
            end
         end else if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL coef_lead[%0d] got valid=%0b want 0", i, out_valid);
         end
      end
   endtask

   task automatic test_random();
      step(1'b0, 0, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
              $urandom_range(0, 9) == 0, $urandom_range(0, 7),
              $urandom_range(0, 255), $urandom_range(0, 29) == 0);
         checks++;
         if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL rand_valid[%0d] got=%0b want=%0b", i, out_valid, exp_valid);
         end else if (exp_valid) begin
            checks++;
            if (out_data !== OUT_W'(exp_data) || out_sat !== exp_sat) begin
               errors++;
               $display("FAIL rand_data[%0d] got data=%0d sat=%0b want data=%0d sat=%0b", i, out_data, out_sat, exp_data, exp_sat);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      step(1'b0, 0, 1'b0, 0, 0, 1'b1);
      step(1'b1, 50, 1'b0, 0, 0, 1'b0);
      step(1'b1, 60, 1'b0, 0, 0, 1'b0);
      step(1'b1, 70, 1'b0, 0, 0, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got valid=%0b want 1", out_valid); end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 10'd0 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL areset_now got valid=%0b data=%0d sat=%0b want 0/0/0", out_valid, out_data, out_sat);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 7; i++) begin
         step(i < 5, (i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0);
         if (i >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'd1) begin
               errors++;
               $display("FAIL areset_impulse[%0d] got valid=%0b data=%0d want valid=1 data=1", i, out_valid, out_data);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ramp();
      test_saturation();
      test_bubbles();
      test_flush();
      test_coef_load();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
